// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war playfield block.
package tug_pkg;

  typedef enum logic [1:0] {PLAY, WIN_L, WIN_R, OVER} tug_state_t;

  localparam logic SIDE_LEFT  = 1'b0;
  localparam logic SIDE_RIGHT = 1'b1;

endpackage

// File: rtl/tug_hold_timer.sv
// Point-win hold timer: counts 0..HOLD_CYCLES-1 while enabled, cleared by load.
module tug_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam int unsigned W = $clog2(HOLD_CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= cnt + W'(1);
    end
  end

  assign done = (cnt == W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/tug_playfield_match.sv
// Tug-of-war playfield: one-hot rope position, point-win hold display and match scoring.
module tug_playfield_match
  import tug_pkg::*;
#(
  parameter int N_LEDS       = 9,
  parameter int SCORE_W      = 3,
  parameter int MATCH_POINTS = 3,
  parameter int HOLD_CYCLES  = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rin,
  input  logic               lin,
  output logic [N_LEDS-1:0]  led,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic               match_over,
  output logic               match_winner
);

  if ((N_LEDS % 2) == 0 || N_LEDS < 3) begin : g_bad_leds
    $error("tug_playfield_match: N_LEDS must be odd and >= 3");
  end
  if (MATCH_POINTS < 1 || MATCH_POINTS > (1 << SCORE_W) - 1) begin : g_bad_points
    $error("tug_playfield_match: MATCH_POINTS out of range for SCORE_W");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("tug_playfield_match: HOLD_CYCLES must be >= 1");
  end

  localparam logic [N_LEDS-1:0] CENTRE = N_LEDS'(1) << (N_LEDS / 2);
  localparam logic [N_LEDS-1:0] LED_R  = N_LEDS'(1);
  localparam logic [N_LEDS-1:0] LED_L  = N_LEDS'(1) << (N_LEDS - 1);

  tug_state_t         state, state_n;
  logic [N_LEDS-1:0]  pos, pos_n;
  logic [SCORE_W-1:0] sl_n, sr_n;
  logic               last_side, last_side_n;
  logic               mv_r, mv_l, in_win, hold_done;

  assign mv_r   = rin & ~lin;
  assign mv_l   = lin & ~rin;
  assign in_win = (state == WIN_L) || (state == WIN_R);

  // Clearing on exit leaves the counter at zero for the next point's first hold cycle.
  tug_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
    .clk   (clk),
    .reset (reset),
    .load  (in_win && hold_done),
    .en    (in_win),
    .done  (hold_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PLAY;
      pos       <= CENTRE;
      score_l   <= '0;
      score_r   <= '0;
      last_side <= SIDE_LEFT;
    end else begin
      state     <= state_n;
      pos       <= pos_n;
      score_l   <= sl_n;
      score_r   <= sr_n;
      last_side <= last_side_n;
    end
  end

  always_comb begin
    state_n     = state;
    pos_n       = pos;
    sl_n        = score_l;
    sr_n        = score_r;
    last_side_n = last_side;
    case (state)
      PLAY: begin
        if (mv_r) begin
          if (pos[0]) begin
            state_n     = WIN_R;
            sr_n        = score_r + SCORE_W'(1);
            last_side_n = SIDE_RIGHT;
          end else begin
            pos_n = pos >> 1;
          end
        end else if (mv_l) begin
          if (pos[N_LEDS-1]) begin
            state_n     = WIN_L;
            sl_n        = score_l + SCORE_W'(1);
            last_side_n = SIDE_LEFT;
          end else begin
            pos_n = pos << 1;
          end
        end
      end
      WIN_L, WIN_R: begin
        if (hold_done) begin
          if (((state == WIN_R) ? score_r : score_l) == SCORE_W'(MATCH_POINTS)) begin
            state_n = OVER;
          end else begin
            state_n = PLAY;
            pos_n   = CENTRE;
          end
        end
      end
      OVER: begin
        state_n = OVER;
      end
      default: begin
        state_n = PLAY;
        pos_n   = CENTRE;
      end
    endcase
  end

  always_comb begin
    led = pos;
    case (state)
      WIN_R:   led = LED_R;
      WIN_L:   led = LED_L;
      OVER:    led = (last_side == SIDE_RIGHT) ? LED_R : LED_L;
      default: led = pos;
    endcase
  end

  assign match_over   = (state == OVER);
  assign match_winner = (state == OVER) && (last_side == SIDE_RIGHT);

endmodule
